app_mult_mem: RTL and testbench

- Memory-side responder for the approximate multiplier's read/write handshake.
- Holds a preloaded table of operand pairs. Answers each `read` pulse with the next pair, and captures each `write` pulse's result into a result table.
- Counts completed transactions and flags the end of the batch and protocol errors.
- Sits beside the multiplier datapath. A bench or host preloads operands and reads results back through a separate side port.

---
 rtl/app_mult_mem.sv | 125 ++++++++++++
 tb/tb_app_mult_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/app_mult_mem.sv
// Memory-side responder for the approximate multiplier: issues preloaded operand
// pairs on read pulses, stores products on write pulses, and tracks batch progress.
module app_mult_mem #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [OUT_W-1:0]  result_in,
    output logic [IN_W-1:0]   A_out,
    output logic [IN_W-1:0]   B_out,
    output logic              op_valid,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [IN_W-1:0]   ld_A,
    input  logic [IN_W-1:0]   ld_B,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [OUT_W-1:0]  rb_data,
    output logic [ADDR_W:0]   rd_cnt,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              all_done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    // Tables are deliberately outside reset so a preload survives rst.
    logic [IN_W-1:0]  opa_q [DEPTH];
    logic [IN_W-1:0]  opb_q [DEPTH];
    logic [OUT_W-1:0] res_q [DEPTH];

    logic [IN_W-1:0]  a_q, a_d;
    logic [IN_W-1:0]  b_q, b_d;
    logic             op_valid_q, op_valid_d;
    logic [ADDR_W:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]  wr_cnt_q, wr_cnt_d;
    logic             all_done_q, all_done_d;
    logic             err_q, err_d;

    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;

    assign rd_idx = rd_cnt_q[ADDR_W-1:0];
    assign wr_idx = wr_cnt_q[ADDR_W-1:0];

    // A read alongside a serviced write frees the slot in the same edge.
    assign wr_ok = write && op_valid_q && (wr_cnt_q != DEPTH_C);
    assign rd_ok = read && (rd_cnt_q != DEPTH_C) && (!op_valid_q || wr_ok);

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        op_valid_d = op_valid_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        all_done_d = all_done_q;
        err_d      = err_q;

        if (wr_ok) begin
            wr_cnt_d   = wr_cnt_q + 1'b1;
            op_valid_d = 1'b0;
            if ((wr_cnt_q + 1'b1) == DEPTH_C) begin
                all_done_d = 1'b1;
            end
        end

        if (rd_ok) begin
            a_d        = opa_q[rd_idx];
            b_d        = opb_q[rd_idx];
            rd_cnt_d   = rd_cnt_q + 1'b1;
            op_valid_d = 1'b1;
        end

        if ((read && !rd_ok) || (write && !wr_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            op_valid_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            op_valid_q <= op_valid_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            all_done_q <= all_done_d;
            err_q      <= err_d;
        end
    end

    // A same-cycle load and read of one entry returns the old contents here.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            opa_q[ld_addr] <= ld_A;
            opb_q[ld_addr] <= ld_B;
        end
        if (!rst && wr_ok) begin
            res_q[wr_idx] <= result_in;
        end
    end

    assign A_out    = a_q;
    assign B_out    = b_q;
    assign op_valid = op_valid_q;
    assign rd_cnt   = rd_cnt_q;
    assign wr_cnt   = wr_cnt_q;
    assign all_done = all_done_q;
    assign err      = err_q;
    assign rb_data  = res_q[rb_addr];

endmodule

// File: tb/tb_app_mult_mem.sv
// Directed bench for app_mult_mem: preload, single pair, full batch, error cases,
// back-to-back transfers, mid-batch reset and load/read collision.
module tb_app_mult_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        read;
    logic        write;
    logic [31:0] result_in;
    logic [15:0] A_out;
    logic [15:0] B_out;
    logic        op_valid;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_A;
    logic [15:0] ld_B;
    logic [2:0]  rb_addr;
    logic [31:0] rb_data;
    logic [3:0]  rd_cnt;
    logic [3:0]  wr_cnt;
    logic        all_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    app_mult_mem #(.IN_W(16), .OUT_W(32), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .result_in(result_in),
        .A_out(A_out), .B_out(B_out), .op_valid(op_valid),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_A(ld_A), .ld_B(ld_B),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .all_done(all_done), .err(err)
    );

    always #5 clk = ~clk;

    // Operand table contents: entry 0 is A=0x0003, B=0x0005.
    function automatic logic [15:0] opa(int i);
        return 16'h0003 + 16'(i * 16);
    endfunction

    function automatic logic [15:0] opb(int i);
        return 16'h0005 + 16'(i * 32);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_read();
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] r);
        write = 1'b1;
        result_in = r;
        tick();
        write = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = 3'(i); ld_A = opa(i); ld_B = opb(i);
            tick();
        end
        ld_en = 1'b0;
        do_reset();
        checks++;
        if (rd_cnt !== 4'd0 || wr_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got rd=%0d wr=%0d want 0 0", rd_cnt, wr_cnt);
        end
        checks++;
        if (A_out !== 16'h0 || B_out !== 16'h0 || op_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out got A=%h B=%h v=%b want 0 0 0", A_out, B_out, op_valid);
        end
        checks++;
        if (all_done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got done=%b err=%b want 0 0", all_done, err);
        end
    endtask

    task automatic test_single();
        do_read();
        checks++;
        if (A_out !== 16'h0003 || B_out !== 16'h0005 || op_valid !== 1'b1 || rd_cnt !== 4'd1) begin
            errors++; $display("FAIL single_read got A=%h B=%h v=%b rd=%0d want 0003 0005 1 1", A_out, B_out, op_valid, rd_cnt);
        end
        do_write(32'h0000000F);
        rb_addr = 3'd0;
        #1;
        checks++;
        if (rb_data !== 32'h0000000F || wr_cnt !== 4'd1 || op_valid !== 1'b0) begin
            errors++; $display("FAIL single_write got rb=%h wr=%0d v=%b want 0000000f 1 0", rb_data, wr_cnt, op_valid);
        end
        checks++;
        if (A_out !== 16'h0003 || err !== 1'b0) begin
            errors++; $display("FAIL single_hold got A=%h err=%b want 0003 0", A_out, err);
        end
    endtask

    task automatic test_full_batch();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_read();
            checks++;
            if (A_out !== opa(i) || B_out !== opb(i)) begin
                errors++; $display("FAIL batch_op%0d got A=%h B=%h want %h %h", i, A_out, B_out, opa(i), opb(i));
            end
            do_write(32'(i * 32'h11));
            checks++;
            if (all_done !== (i == 7)) begin
                errors++; $display("FAIL batch_done%0d got %b want %b", i, all_done, (i == 7));
            end
        end
        checks++;
        if (wr_cnt !== 4'd8 || rd_cnt !== 4'd8 || err !== 1'b0) begin
            errors++; $display("FAIL batch_end got wr=%0d rd=%0d err=%b want 8 8 0", wr_cnt, rd_cnt, err);
        end
        for (int i = 0; i < 8; i++) begin
            rb_addr = 3'(i);
            #1;
            checks++;
            if (rb_data !== 32'(i * 32'h11)) begin
                errors++; $display("FAIL batch_rb%0d got %h want %h", i, rb_data, 32'(i * 32'h11));
            end
        end
        do_read();
        checks++;
        if (err !== 1'b1 || rd_cnt !== 4'd8 || A_out !== opa(7) || op_valid !== 1'b0) begin
            errors++; $display("FAIL batch_exhaust got err=%b rd=%0d A=%h v=%b want 1 8 %h 0", err, rd_cnt, A_out, op_valid, opa(7));
        end
        do_write(32'h12345678);
        rb_addr = 3'd7;
        #1;
        checks++;
        if (wr_cnt !== 4'd8 || rb_data !== 32'h77 || all_done !== 1'b1) begin
            errors++; $display("FAIL batch_late_write got wr=%0d rb=%h done=%b want 8 77 1", wr_cnt, rb_data, all_done);
        end
    endtask

    task automatic test_double_read();
        do_reset();
        do_read();
        do_read();
        checks++;
        if (A_out !== opa(0) || rd_cnt !== 4'd1 || err !== 1'b1 || op_valid !== 1'b1) begin
            errors++; $display("FAIL dbl_read got A=%h rd=%0d err=%b v=%b want %h 1 1 1", A_out, rd_cnt, err, op_valid, opa(0));
        end
        do_write(32'h0);
        checks++;
        if (err !== 1'b1 || wr_cnt !== 4'd1) begin
            errors++; $display("FAIL err_sticky got err=%b wr=%0d want 1 1", err, wr_cnt);
        end
    endtask

    task automatic test_write_no_read();
        do_reset();
        do_write(32'hDEADBEEF);
        checks++;
        if (wr_cnt !== 4'd0 || err !== 1'b1 || op_valid !== 1'b0) begin
            errors++; $display("FAIL orphan_write got wr=%0d err=%b v=%b want 0 1 0", wr_cnt, err, op_valid);
        end
        for (int i = 0; i < 8; i++) begin
            rb_addr = 3'(i);
            #1;
            checks++;
            if (rb_data !== 32'(i * 32'h11)) begin
                errors++; $display("FAIL orphan_rb%0d got %h want %h", i, rb_data, 32'(i * 32'h11));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_read();
        for (int k = 0; k < 2; k++) begin
            read = 1'b1;
            do_write(32'hAAAA0000 + 32'(k));
            read = 1'b0;
            rb_addr = 3'(k);
            #1;
            checks++;
            if (rb_data !== 32'hAAAA0000 + 32'(k) || wr_cnt !== 4'(k + 1)) begin
                errors++; $display("FAIL b2b_store%0d got rb=%h wr=%0d want %h %0d", k, rb_data, wr_cnt, 32'hAAAA0000 + 32'(k), k + 1);
            end
            checks++;
            if (A_out !== opa(k + 1) || B_out !== opb(k + 1) || op_valid !== 1'b1 || rd_cnt !== 4'(k + 2) || err !== 1'b0) begin
                errors++; $display("FAIL b2b_next%0d got A=%h B=%h v=%b rd=%0d err=%b want %h %h 1 %0d 0",
                                   k, A_out, B_out, op_valid, rd_cnt, err, opa(k + 1), opb(k + 1), k + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_read();
            do_write(32'h100 + 32'(i));
        end
        do_reset();
        checks++;
        if (rd_cnt !== 4'd0 || wr_cnt !== 4'd0 || op_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got rd=%0d wr=%0d v=%b want 0 0 0", rd_cnt, wr_cnt, op_valid);
        end
        do_read();
        checks++;
        if (A_out !== opa(0) || B_out !== opb(0) || rd_cnt !== 4'd1 || err !== 1'b0 || all_done !== 1'b0) begin
            errors++; $display("FAIL mid_restart got A=%h B=%h rd=%0d err=%b done=%b want %h %h 1 0 0",
                               A_out, B_out, rd_cnt, err, all_done, opa(0), opb(0));
        end
        for (int i = 0; i < 3; i++) begin
            rb_addr = 3'(i);
            #1;
            checks++;
            if (rb_data !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL mid_rb%0d got %h want %h", i, rb_data, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_load_collision();
        do_reset();
        ld_en = 1'b1; ld_addr = 3'd0; ld_A = 16'h1234; ld_B = 16'h5678;
        do_read();
        ld_en = 1'b0;
        checks++;
        if (A_out !== opa(0) || B_out !== opb(0)) begin
            errors++; $display("FAIL ld_collide got A=%h B=%h want %h %h", A_out, B_out, opa(0), opb(0));
        end
        do_reset();
        do_read();
        checks++;
        if (A_out !== 16'h1234 || B_out !== 16'h5678) begin
            errors++; $display("FAIL ld_new got A=%h B=%h want 1234 5678", A_out, B_out);
        end
    endtask

    initial begin
        rst = 1'b0; read = 1'b0; write = 1'b0; result_in = '0;
        ld_en = 1'b0; ld_addr = '0; ld_A = '0; ld_B = '0; rb_addr = '0;
        test_reset();
        test_single();
        test_full_batch();
        test_double_read();
        test_write_no_read();
        test_back_to_back();
        test_reset_mid();
        test_load_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
